// File: rtl/tx_word_sender_if.sv
`default_nettype none
// ============================================================================
// Module   : tx_word_sender_if
// Brief    : Word-write side and transmitter handshake of tx_word_sender
// Revision : 1.0
// ============================================================================
interface tx_word_sender_if #(
  parameter int N_BITS_DATA  = 8,
  parameter int N_BYTES_WORD = 4
);
  logic                                wr_en;
  logic [N_BITS_DATA*N_BYTES_WORD-1:0] wr_data;
  logic                                tx_done_i;
  logic                                tx_start_o;
  logic [N_BITS_DATA-1:0]              tx_data_o;
  logic                                full_o;
  logic                                empty_o;
  logic                                busy_o;
  logic                                word_sent_o;
  logic                                overflow_o;

  // master: the debug-side writer plus the transmitter; slave: the sender
  modport master (
    output wr_en, wr_data, tx_done_i,
    input  tx_start_o, tx_data_o, full_o, empty_o, busy_o, word_sent_o, overflow_o
  );

  modport slave (
    input  wr_en, wr_data, tx_done_i,
    output tx_start_o, tx_data_o, full_o, empty_o, busy_o, word_sent_o, overflow_o
  );
endinterface
`default_nettype wire

// File: rtl/tx_word_sender.sv
`default_nettype none
// ============================================================================
// Module   : tx_word_sender
// Brief    : Word FIFO feeding the UART transmitter one byte at a time, LSB first
// Revision : 1.0
// ============================================================================
module tx_word_sender #(
  parameter int N_BITS_DATA     = 8,
  parameter int N_BYTES_WORD    = 4,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic           clock,
  input  logic           reset,
  tx_word_sender_if.slave bus
);
  localparam int c_word_w = N_BITS_DATA * N_BYTES_WORD;
  localparam int c_depth  = 1 << FIFO_DEPTH_LOG2;
  localparam int c_idx_w  = (N_BYTES_WORD > 1) ? $clog2(N_BYTES_WORD) : 1;

  localparam logic [c_idx_w-1:0]         c_last_idx = c_idx_w'(N_BYTES_WORD - 1);
  localparam logic [c_idx_w-1:0]         c_idx_one  = c_idx_w'(1);
  localparam logic [FIFO_DEPTH_LOG2-1:0] c_ptr_one  = FIFO_DEPTH_LOG2'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   c_cnt_one  = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2:0]   c_cnt_full = (FIFO_DEPTH_LOG2 + 1)'(c_depth);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARM       = 3'd1,
    S_START     = 3'd2,
    S_WAIT_BUSY = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  state_t                       r_state;
  state_t                       w_next_state;

  logic [c_word_w-1:0]          r_mem [c_depth];
  logic [FIFO_DEPTH_LOG2-1:0]   r_wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0]   r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]     r_count;
  logic                         r_overflow;

  logic [c_word_w-1:0]          r_word;
  logic [c_idx_w-1:0]           r_byte_idx;
  logic [N_BITS_DATA-1:0]       r_tx_data;
  logic                         r_word_sent;

  logic                         w_full;
  logic                         w_empty;
  logic                         w_push;
  logic                         w_pop;
  logic                         w_advance;
  logic                         w_word_done;
  logic                         w_tx_start;
  logic                         w_busy;
  logic [c_word_w-1:0]          w_head;
  logic [c_idx_w-1:0]           w_next_idx;
  logic [N_BITS_DATA-1:0]       w_bytes [N_BYTES_WORD];

  assign w_full     = (r_count == c_cnt_full);
  assign w_empty    = (r_count == '0);
  assign w_push     = bus.wr_en & ~w_full;
  assign w_head     = r_mem[r_rd_ptr];
  assign w_next_idx = r_byte_idx + c_idx_one;

  for (genvar k = 0; k < N_BYTES_WORD; k++) begin : g_bytes
    assign w_bytes[k] = r_word[k*N_BITS_DATA +: N_BITS_DATA];
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // tx_start_o and busy_o decode the state only: tx_done_i must never reach them
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_advance    = 1'b0;
    w_word_done  = 1'b0;
    w_tx_start   = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_ARM;
        end
      end
      S_ARM: begin
        if (bus.tx_done_i) begin
          w_next_state = S_START;
        end
      end
      S_START: begin
        w_tx_start   = 1'b1;
        w_next_state = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (!bus.tx_done_i) begin
          w_next_state = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (bus.tx_done_i) begin
          if (r_byte_idx == c_last_idx) begin
            w_word_done  = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_advance    = 1'b1;
            w_next_state = S_ARM;
          end
        end
      end
      default: begin
        w_busy       = 1'b0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------- FIFO
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
      // judged on the registered full flag, so a same-cycle pop does not rescue it
      if (bus.wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ----------------------------------------------------- word / byte path
  always_ff @(posedge clock) begin
    if (reset) begin
      r_word      <= '0;
      r_byte_idx  <= '0;
      r_tx_data   <= '0;
      r_word_sent <= 1'b0;
    end else begin
      r_word_sent <= w_word_done;
      if (w_pop) begin
        r_word     <= w_head;
        r_byte_idx <= '0;
        r_tx_data  <= w_head[N_BITS_DATA-1:0];
      end else if (w_advance) begin
        r_byte_idx <= w_next_idx;
        r_tx_data  <= w_bytes[w_next_idx];
      end
    end
  end

  assign bus.tx_start_o  = w_tx_start;
  assign bus.tx_data_o   = r_tx_data;
  assign bus.full_o      = w_full;
  assign bus.empty_o     = w_empty;
  assign bus.busy_o      = w_busy;
  assign bus.word_sent_o = r_word_sent;
  assign bus.overflow_o  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_tx_word_sender.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for tx_word_sender: transmitter model, byte-stream reference queue and
// directed plus randomized word traffic.
module tb_tx_word_sender;
  localparam int c_frame = 16 * 11;

  logic clock    = 1'b0;
  logic reset    = 1'b1;
  logic hold_low = 1'b0;

  tx_word_sender_if bus ();

  tx_word_sender dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // transmitter: idle -> accepts a start -> busy for one full frame
  logic m_idle;
  int   m_cnt;
  always @(posedge clock) begin
    if (reset) begin
      m_idle <= 1'b1;
      m_cnt  <= 0;
    end else if (m_idle) begin
      if (bus.tx_start_o) begin
        m_idle <= 1'b0;
        m_cnt  <= c_frame - 1;
      end
    end else if (m_cnt == 0) begin
      m_idle <= 1'b1;
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign bus.tx_done_i = m_idle & ~hold_low;

  // bytes are captured on the falling edge of each start cycle
  logic [7:0] got [$];
  int         ws_cnt = 0;
  int         st_cnt = 0;
  always @(negedge clock) begin
    if (bus.tx_start_o) begin
      got.push_back(bus.tx_data_o);
      st_cnt <= st_cnt + 1;
    end
    if (bus.word_sent_o) begin
      ws_cnt <= ws_cnt + 1;
    end
  end

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  int         got_base;
  int         ws_base;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got_v, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.wr_en  = 1'b0;
    hold_low   = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic begin_test();
    exp_q.delete();
    got_base = got.size();
    ws_base  = ws_cnt;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(w >> (8 * k)));
  endtask

  task automatic write_word(input logic [31:0] w);
    bus.wr_en   = 1'b1;
    bus.wr_data = w;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int n);
    int b = 0;
    while ((ws_cnt - ws_base) < n && b < 20000) begin
      tick();
      b++;
    end
    repeat (4) tick();
    check(tag, ws_cnt - ws_base, n);
  endtask

  task automatic check_stream(input string tag);
    int n = got.size() - got_base;
    check({tag, "_len"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check({tag, "_byte"}, got[got_base + i], exp_q[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"},    bus.tx_start_o,  1'b0);
    check({tag, "_data"},     bus.tx_data_o,   8'h00);
    check({tag, "_wsent"},    bus.word_sent_o, 1'b0);
    check({tag, "_overflow"}, bus.overflow_o,  1'b0);
    check({tag, "_busy"},     bus.busy_o,      1'b0);
    check({tag, "_empty"},    bus.empty_o,     1'b1);
    check({tag, "_full"},     bus.full_o,      1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    int b, n, rise, ng, gbad, starts, unstable, gaps, n55, nw;
    logic pd;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // single word: latency 3, byte order, 2-cycle byte overhead
    begin_test();
    push_word(32'hDEADBEEF);
    write_word(32'hDEADBEEF);
    check("lat_empty", bus.empty_o, 1'b0);
    tick();
    check("lat_arm_busy", bus.busy_o, 1'b1);
    check("lat_arm_start", bus.tx_start_o, 1'b0);
    check("lat_arm_data", bus.tx_data_o, 8'hEF);
    tick();
    check("lat_start", bus.tx_start_o, 1'b1);
    rise = -1; n = 0; ng = 0; gbad = 0; b = 0; pd = bus.tx_done_i;
    while (n < 1 && b < 20000) begin
      tick();
      b++;
      if (bus.tx_start_o) begin
        if (rise >= 0) begin
          ng++;
          if (b - rise != 2) gbad++;
        end
        rise = -1;
      end else if (bus.tx_done_i && !pd) begin
        rise = b;
      end
      pd = bus.tx_done_i;
      if (bus.word_sent_o) n++;
    end
    check("single_overhead_n", ng, 3);
    check("single_overhead_bad", gbad, 0);
    wait_words("single_wsent", 1);
    check_stream("single");
    check("single_busy", bus.busy_o, 1'b0);
    check("single_empty", bus.empty_o, 1'b1);

    // handshake stall in ARM
    do_reset();
    begin_test();
    hold_low = 1'b1;
    w = $urandom;
    push_word(w);
    write_word(w);
    starts = 0; unstable = 0;
    repeat (50) begin
      tick();
      if (bus.tx_start_o) starts++;
      if (bus.tx_data_o !== w[7:0]) unstable++;
    end
    check("stall_starts", starts, 0);
    check("stall_unstable", unstable, 0);
    check("stall_busy", bus.busy_o, 1'b1);
    hold_low = 1'b0;
    tick();
    check("stall_fire", bus.tx_start_o, 1'b1);
    wait_words("stall_wsent", 1);
    check_stream("stall");

    // overflow: sender parked on a primer word, then 5 writes
    do_reset();
    begin_test();
    hold_low = 1'b1;
    push_word(32'h0A0B0C0D);
    write_word(32'h0A0B0C0D);
    repeat (3) tick();
    for (int i = 1; i <= 5; i++) begin
      w = 32'h11111111 * i;
      if (i <= 4) push_word(w);
      write_word(w);
      check("ovf_full", bus.full_o, (i >= 4) ? 1'b1 : 1'b0);
      check("ovf_flag", bus.overflow_o, (i == 5) ? 1'b1 : 1'b0);
    end
    hold_low = 1'b0;
    wait_words("ovf_wsent", 5);
    check_stream("ovf");
    n55 = 0;
    for (int i = got_base; i < got.size(); i++) if (got[i] == 8'h55) n55++;
    check("ovf_no55", n55, 0);
    check("ovf_sticky", bus.overflow_o, 1'b1);

    // back-to-back: second write lands in the pop cycle
    do_reset();
    begin_test();
    for (int i = 0; i < 2; i++) begin
      w = $urandom;
      push_word(w);
      write_word(w);
    end
    check("b2b_empty", bus.empty_o, 1'b0);
    check("b2b_full", bus.full_o, 1'b0);
    n = 0; gaps = 0; b = 0;
    while (n < 2 && b < 20000) begin
      tick();
      b++;
      if (bus.word_sent_o) n++;
      if (!bus.busy_o && n < 2) gaps++;
    end
    check("b2b_gap", gaps, 1);
    wait_words("b2b_wsent", 2);
    check_stream("b2b");

    // write+pop keeps count at 1: four more words only then fill the FIFO
    do_reset();
    begin_test();
    hold_low = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      w = $urandom;
      push_word(w);
      write_word(w);
      if (i >= 4) check("wp_full", bus.full_o, (i == 5) ? 1'b1 : 1'b0);
    end
    check("wp_overflow", bus.overflow_o, 1'b0);
    hold_low = 1'b0;
    wait_words("wp_wsent", 5);
    check_stream("wp");

    // reset mid-word after the second start
    do_reset();
    begin_test();
    write_word($urandom);
    n = 0; b = 0;
    while (n < 2 && b < 5000) begin
      tick();
      b++;
      if (bus.tx_start_o) n++;
    end
    check("midrst_starts", n, 2);
    reset = 1'b1;
    tick();
    check_reset_outputs("midrst");
    reset = 1'b0;
    n  = st_cnt;
    nw = ws_cnt;
    repeat (600) tick();
    check("midrst_no_start", st_cnt - n, 0);
    check("midrst_no_wsent", ws_cnt - nw, 0);

    // randomized bursts of up to 4 words with random spacing
    do_reset();
    begin_test();
    nw = 0;
    for (int r = 0; r < 6; r++) begin
      int k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) begin
        w = $urandom;
        push_word(w);
        write_word(w);
        repeat ($urandom_range(0, 2)) tick();
      end
      nw += k;
      wait_words("rand_wsent", nw);
    end
    check_stream("rand");
    check("rand_overflow", bus.overflow_o, 1'b0);
    check("rand_empty", bus.empty_o, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
